vx_cache_core_rsp_merge: RTL and testbench

Return-path counterpart of the cache's core-request bank selector: collects per-bank read responses and assembles them into a single registered core response. Each bank returns one word per cycle with its originating lane (tid) and core tag. A round-robin arbiter picks a lead bank, and all other banks holding the same tag for distinct lanes are merged into the same response beat. The block sits between the bank array outputs and the cache's core response port.

---
 rtl/vx_cache_core_rsp_merge.sv | 123 ++++++++++++
 tb/tb_vx_cache_core_rsp_merge.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_cache_core_rsp_merge.sv
// Merges per-bank read responses into one registered core response beat.
// Same-tag merging across banks is enabled by defining CACHE_RSP_MERGE_EN.
module vx_cache_core_rsp_merge #(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned NUM_REQUESTS   = 4,
  parameter int unsigned WORD_SIZE      = 4,
  parameter int unsigned CORE_TAG_WIDTH = 8,
  localparam int unsigned TW = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_BANKS-1:0]                  per_bank_rsp_valid,
  input  logic [NUM_BANKS*TW-1:0]               per_bank_rsp_tid,
  input  logic [NUM_BANKS*WORD_SIZE*8-1:0]      per_bank_rsp_data,
  input  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]   per_bank_rsp_tag,
  output logic [NUM_BANKS-1:0]                  per_bank_rsp_ready,
  output logic [NUM_REQUESTS-1:0]               core_rsp_valid,
  output logic [NUM_REQUESTS*WORD_SIZE*8-1:0]   core_rsp_data,
  output logic [CORE_TAG_WIDTH-1:0]             core_rsp_tag,
  input  logic                                  core_rsp_ready
);

  localparam int unsigned NB  = NUM_BANKS;
  localparam int unsigned NR  = NUM_REQUESTS;
  localparam int unsigned DW  = WORD_SIZE * 8;
  localparam int unsigned CTW = CORE_TAG_WIDTH;
  localparam int unsigned PW  = (NB > 1) ? $clog2(NB) : 1;

  logic [NR-1:0]    valid_q, valid_d;
  logic [NR*DW-1:0] data_q, data_d;
  logic [CTW-1:0]   tag_q, tag_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NB-1:0]    sel_c;
  logic             found_c;
  logic [PW-1:0]    lead_c;
  logic [CTW-1:0]   lead_tag_c;
  logic             can_load_c;

  // Round-robin lead selection plus same-tag, distinct-lane followers.
  always_comb begin : merge_sel
    logic [PW-1:0] idx;
`ifdef CACHE_RSP_MERGE_EN
    logic [NR-1:0] claimed;
    logic [TW-1:0] lane;
    claimed = '0;
    lane    = '0;
`endif
    sel_c      = '0;
    found_c    = 1'b0;
    lead_c     = '0;
    lead_tag_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      // NB is a power of two, so PW-bit wraparound is the modulo.
      idx = rr_ptr_q + PW'(i);
`ifdef CACHE_RSP_MERGE_EN
      lane = (NR > 1) ? per_bank_rsp_tid[idx*TW +: TW] : '0;
`endif
      if (per_bank_rsp_valid[idx]) begin
        if (!found_c) begin
          found_c     = 1'b1;
          lead_c      = idx;
          lead_tag_c  = per_bank_rsp_tag[idx*CTW +: CTW];
          sel_c[idx]  = 1'b1;
`ifdef CACHE_RSP_MERGE_EN
          claimed[lane] = 1'b1;
        end else if (per_bank_rsp_tag[idx*CTW +: CTW] == lead_tag_c && !claimed[lane]) begin
          sel_c[idx]    = 1'b1;
          claimed[lane] = 1'b1;
`endif
        end
      end
    end
  end

  // Output register load: accept-and-reload in the same edge when the core is ready.
  always_comb begin : next_state
    logic [TW-1:0] ln;
    ln         = '0;
    can_load_c = ~|valid_q | core_rsp_ready;
    valid_d    = valid_q;
    data_d     = data_q;
    tag_d      = tag_q;
    rr_ptr_d   = rr_ptr_q;
    if (can_load_c) begin
      valid_d = '0;
      if (found_c) begin
        data_d   = '0;
        tag_d    = lead_tag_c;
        rr_ptr_d = (NB > 1) ? lead_c + PW'(1) : '0;
        for (int b = 0; b < NB; b++) begin
          if (sel_c[b]) begin
            ln                 = (NR > 1) ? per_bank_rsp_tid[b*TW +: TW] : '0;
            valid_d[ln]        = 1'b1;
            data_d[ln*DW +: DW] = per_bank_rsp_data[b*DW +: DW];
          end
        end
      end
    end
  end

  assign per_bank_rsp_ready = (reset && can_load_c) ? sel_c : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign core_rsp_valid = valid_q;
  assign core_rsp_data  = data_q;
  assign core_rsp_tag   = tag_q;

endmodule

// File: tb/tb_vx_cache_core_rsp_merge.sv
// Scoreboard bench for vx_cache_core_rsp_merge (follows CACHE_RSP_MERGE_EN if defined).
module tb_vx_cache_core_rsp_merge;
  localparam int unsigned NB  = 4;
  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned CTW = 8;
  localparam int unsigned TW  = 2;
`ifdef CACHE_RSP_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0]  tid;
    logic [CTW-1:0] tag;
    logic [DW-1:0]  data;
  } bank_rsp_t;

  typedef struct packed {
    logic [NR-1:0]    vld;
    logic [NR*DW-1:0] data;
    logic [CTW-1:0]   tag;
  } beat_t;

  logic                clk;
  logic                reset;
  logic [NB-1:0]       per_bank_rsp_valid;
  logic [NB*TW-1:0]    per_bank_rsp_tid;
  logic [NB*DW-1:0]    per_bank_rsp_data;
  logic [NB*CTW-1:0]   per_bank_rsp_tag;
  logic [NB-1:0]       per_bank_rsp_ready;
  logic [NR-1:0]       core_rsp_valid;
  logic [NR*DW-1:0]    core_rsp_data;
  logic [CTW-1:0]      core_rsp_tag;
  logic                core_rsp_ready;

  vx_cache_core_rsp_merge #(
    .NUM_BANKS(NB), .NUM_REQUESTS(NR), .WORD_SIZE(4), .CORE_TAG_WIDTH(CTW)
  ) dut (
    .clk(clk), .reset(reset),
    .per_bank_rsp_valid(per_bank_rsp_valid), .per_bank_rsp_tid(per_bank_rsp_tid),
    .per_bank_rsp_data(per_bank_rsp_data), .per_bank_rsp_tag(per_bank_rsp_tag),
    .per_bank_rsp_ready(per_bank_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bank_rsp_t     bank_q[NB][$];
  beat_t         sb[$];
  int            n_chk;
  int            n_pass;
  int            m_rr;
  logic [NR-1:0] m_out_vld;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] lane_data(input int i);
    return core_rsp_data[i*DW +: DW];
  endfunction

  task automatic push_rsp(input int b, input int tid, input int tag, input int data);
    bank_rsp_t r;
    r.tid  = TW'(tid);
    r.tag  = CTW'(tag);
    r.data = DW'(data);
    bank_q[b].push_back(r);
  endtask

  function automatic int pending();
    int n = 0;
    for (int b = 0; b < NB; b++) n += bank_q[b].size();
    return n;
  endfunction

  task automatic drive_banks();
    for (int b = 0; b < NB; b++) begin
      if (bank_q[b].size() > 0) begin
        per_bank_rsp_valid[b]            = 1'b1;
        per_bank_rsp_tid[b*TW +: TW]     = bank_q[b][0].tid;
        per_bank_rsp_tag[b*CTW +: CTW]   = bank_q[b][0].tag;
        per_bank_rsp_data[b*DW +: DW]    = bank_q[b][0].data;
      end else begin
        per_bank_rsp_valid[b]            = 1'b0;
        per_bank_rsp_tid[b*TW +: TW]     = '0;
        per_bank_rsp_tag[b*CTW +: CTW]   = '0;
        per_bank_rsp_data[b*DW +: DW]    = '0;
      end
    end
  endtask

  // Reference: find lead from the pointer, then admit same-tag banks whose lane is still free.
  function automatic void model_merge(output logic [NB-1:0] set, output logic found,
                                      output int lead, output beat_t bt);
    int b;
    logic [CTW-1:0] lt;
    logic clash;
    set = '0; found = 1'b0; lead = 0; bt = '0; lt = '0; clash = 1'b0;
    for (int off = 0; off < NB; off++) begin
      b = (m_rr + off) % NB;
      if (!found && bank_q[b].size() > 0) begin
        found = 1'b1; lead = b; lt = bank_q[b][0].tag; set[b] = 1'b1;
      end
    end
    if (found && MERGE) begin
      for (int off = 1; off < NB; off++) begin
        b = (lead + off) % NB;
        if (bank_q[b].size() > 0 && bank_q[b][0].tag == lt) begin
          clash = 1'b0;
          for (int c = 0; c < NB; c++)
            if (set[c] && bank_q[c][0].tid == bank_q[b][0].tid) clash = 1'b1;
          if (!clash) set[b] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NB; c++) begin
      if (set[c]) begin
        bt.vld[bank_q[c][0].tid] = 1'b1;
        bt.data[bank_q[c][0].tid*DW +: DW] = bank_q[c][0].data;
      end
    end
    bt.tag = lt;
  endfunction

  task automatic cycle();
    logic [NB-1:0] exp_rdy;
    logic          found;
    logic          can;
    int            lead;
    beat_t         nb;
    beat_t         eb;
    @(negedge clk);
    chk("core_vld", 128'(core_rsp_valid), 128'(m_out_vld));
    if (core_rsp_ready && m_out_vld != 0) begin
      if (sb.size() == 0) chk("sb_underflow", 128'(0), 128'(1));
      else begin
        eb = sb.pop_front();
        chk("core_data", 128'(core_rsp_data), 128'(eb.data));
        chk("core_tag", 128'(core_rsp_tag), 128'(eb.tag));
      end
    end
    model_merge(exp_rdy, found, lead, nb);
    can = (m_out_vld == 0) || core_rsp_ready;
    if (!can || !reset) exp_rdy = '0;
    chk("bank_rdy", 128'(per_bank_rsp_ready), 128'(exp_rdy));
    if (can && found && reset) sb.push_back(nb);
    @(posedge clk);
    #1;
    if (reset) begin
      if (can) begin
        m_out_vld = found ? nb.vld : '0;
        if (found) m_rr = (lead + 1) % NB;
      end
      for (int b = 0; b < NB; b++) if (exp_rdy[b]) void'(bank_q[b].pop_front());
    end
    drive_banks();
  endtask

  task automatic clear_model();
    for (int b = 0; b < NB; b++) bank_q[b].delete();
    sb.delete();
    m_rr = 0;
    m_out_vld = '0;
    drive_banks();
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain();
    int budget = 60;
    core_rsp_ready = 1'b1;
    while ((pending() > 0 || m_out_vld != 0) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_budget", 128'(pending() == 0 && m_out_vld == 0), 128'(1));
  endtask

  // Banks must hold their response until it is consumed.
  logic [NB-1:0]     pv, pr;
  logic [NB*TW-1:0]  ptid;
  logic [NB*CTW-1:0] ptag;
  logic [NB*DW-1:0]  pdata;
  logic              prst;
  always @(negedge clk) begin
    if (reset && prst) begin
      for (int b = 0; b < NB; b++) begin
        if (pv[b] && !pr[b])
          assert (per_bank_rsp_valid[b] && per_bank_rsp_tid[b*TW +: TW] == ptid[b*TW +: TW]
                  && per_bank_rsp_tag[b*CTW +: CTW] == ptag[b*CTW +: CTW]
                  && per_bank_rsp_data[b*DW +: DW] == pdata[b*DW +: DW])
          else $error("FAIL bank_hold: bank %0d changed before ready", b);
      end
    end
    pv = per_bank_rsp_valid; pr = per_bank_rsp_ready;
    ptid = per_bank_rsp_tid; ptag = per_bank_rsp_tag; pdata = per_bank_rsp_data;
    prst = reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0; prst = 1'b0;
    reset = 1'b1; core_rsp_ready = 1'b0;
    m_rr = 0; m_out_vld = '0;
    per_bank_rsp_valid = '0; per_bank_rsp_tid = '0;
    per_bank_rsp_data = '0; per_bank_rsp_tag = '0;
    #2 reset = 1'b0;

    // Reset with all banks valid, then release idle.
    for (int b = 0; b < NB; b++) push_rsp(b, b, 8'h3C, 32'hDEAD_0000 + b);
    drive_banks();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_vld", 128'(core_rsp_valid), 128'(0));
      chk("rst_tag", 128'(core_rsp_tag), 128'(0));
      chk("rst_data", 128'(core_rsp_data), 128'(0));
      chk("rst_rdy", 128'(per_bank_rsp_ready), 128'(0));
    end
    clear_model();
    @(posedge clk);
    #1 reset = 1'b1;
    core_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("idle_vld", 128'(core_rsp_valid), 128'(0));
      chk("idle_data", 128'(core_rsp_data), 128'(0));
      chk("idle_rr", 128'(dut.rr_ptr_q), 128'(0));
    end

    // Full merge: four banks, one tag, distinct lanes.
    for (int b = 0; b < NB; b++) push_rsp(b, b, 8'h5A, 32'h10 + b);
    drive_banks();
    #1 chk("full_rdy", 128'(per_bank_rsp_ready), 128'(MERGE ? 4'hF : 4'h1));
    cycle();
    chk("full_vld", 128'(core_rsp_valid), 128'(MERGE ? 4'hF : 4'h1));
    chk("full_tag", 128'(core_rsp_tag), 128'(8'h5A));
    chk("full_rr", 128'(dut.rr_ptr_q), 128'(1));
    for (int i = 0; i < NR; i++)
      chk("full_lane", 128'(lane_data(i)), 128'((MERGE || i == 0) ? 32'h10 + i : 0));
    for (int k = 1; k < NR; k++) begin
      cycle();
      chk("single_vld", 128'(core_rsp_valid), 128'(MERGE ? 4'h0 : (4'h1 << k)));
      chk("single_data", 128'(lane_data(k)), 128'(MERGE ? 32'h10 + k : 32'h10 + k));
    end
    drain();

    // Tag split with round-robin alternation.
    reset_dut();
    core_rsp_ready = 1'b1;
    push_rsp(0, 0, 8'h01, 32'hA0); push_rsp(0, 0, 8'h01, 32'hA1);
    push_rsp(2, 1, 8'h02, 32'hB0); push_rsp(2, 1, 8'h02, 32'hB1);
    drive_banks();
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("split_vld", 128'(core_rsp_valid), 128'(k % 2 == 0 ? 4'b0001 : 4'b0010));
      chk("split_tag", 128'(core_rsp_tag), 128'(k % 2 == 0 ? 8'h01 : 8'h02));
    end
    drain();

    // Same tag, same lane: second bank is deferred.
    reset_dut();
    core_rsp_ready = 1'b1;
    push_rsp(1, 2, 8'h07, 32'h11);
    push_rsp(3, 2, 8'h07, 32'h33);
    drive_banks();
    cycle();
    chk("tid_vld1", 128'(core_rsp_valid), 128'(4'b0100));
    chk("tid_data1", 128'(lane_data(2)), 128'(32'h11));
    cycle();
    chk("tid_vld2", 128'(core_rsp_valid), 128'(4'b0100));
    chk("tid_data2", 128'(lane_data(2)), 128'(32'h33));
    drain();

    // Back-pressure hold, then no-bubble reload.
    for (int b = 0; b < NB; b++) begin
      push_rsp(b, b, 8'h20 + b, 32'h50 + b);
      push_rsp(b, b, 8'h30 + b, 32'h60 + b);
    end
    drive_banks();
    cycle();
    chk("bp_load_vld", 128'(core_rsp_valid), 128'(4'b0001));
    core_rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("bp_vld", 128'(core_rsp_valid), 128'(4'b0001));
      chk("bp_tag", 128'(core_rsp_tag), 128'(8'h20));
      chk("bp_data", 128'(lane_data(0)), 128'(32'h50));
      chk("bp_rdy", 128'(per_bank_rsp_ready), 128'(0));
    end
    core_rsp_ready = 1'b1;
    cycle();
    chk("bp_next_vld", 128'(core_rsp_valid), 128'(4'b0010));
    chk("bp_next_tag", 128'(core_rsp_tag), 128'(8'h21));
    drain();

    // Reset while a response is held drops it.
    core_rsp_ready = 1'b0;
    push_rsp(0, 0, 8'h44, 32'h77);
    push_rsp(1, 1, 8'h45, 32'h78);
    drive_banks();
    cycle();
    chk("mid_load_vld", 128'(core_rsp_valid), 128'(4'b0001));
    cycle();
    #2 reset = 1'b0;
    #1;
    chk("arst_vld", 128'(core_rsp_valid), 128'(0));
    chk("arst_tag", 128'(core_rsp_tag), 128'(0));
    chk("arst_data", 128'(core_rsp_data), 128'(0));
    clear_model();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    core_rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("post_rst_vld", 128'(core_rsp_valid), 128'(0));
    end

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
